// File: rtl/seg7_scan_if.sv
// Bus between a multiplexed 7-segment display driver and its readback decoder.
// Signalling: there is no valid/ready handshake. The driver side (master) presents
// seg/an every cycle and the monitor samples them unconditionally. The decoder
// (slave) raises frame_valid for exactly one cycle when digits/digit_err change.
// There is no backpressure, so a consumer must take the frame in that cycle.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    En;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;

  modport master (
    output En, seg, an,
    input  digits, digit_err, frame_valid
  );

  modport slave (
    input  En, seg, an,
    output digits, digit_err, frame_valid
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex value shown on each digit of a time-multiplexed 7-segment bus.
// A digit is captured once its segment/anode sample has been stable for
// STABLE_CYCLES. A frame is published once every digit has been captured.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic        clk,
  input logic        rst_n,
  seg7_scan_if.slave bus
);
  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam int            IW      = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]              seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   an_q, an_p;
  logic [CW-1:0]           cnt, cnt_next;
  logic                    armed;
  logic                    sel_valid;
  logic [IW-1:0]           sel_idx;
  logic                    same;
  logic                    capture;
  logic [4:0]              dec;
  logic [NUM_DIGITS-1:0]   seen;
  logic                    seen_full;
  logic [4*NUM_DIGITS-1:0] shadow_val, digits_q;
  logic [NUM_DIGITS-1:0]   shadow_err, err_q;
  logic                    fv_q;

  // Returns {err, value}; err set for any pattern outside the hex glyph set.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h3F:   decode_seg = 5'h00;
      7'h06:   decode_seg = 5'h01;
      7'h5B:   decode_seg = 5'h02;
      7'h4F:   decode_seg = 5'h03;
      7'h66:   decode_seg = 5'h04;
      7'h6D:   decode_seg = 5'h05;
      7'h7D:   decode_seg = 5'h06;
      7'h07:   decode_seg = 5'h07;
      7'h7F:   decode_seg = 5'h08;
      7'h6F:   decode_seg = 5'h09;
      7'h77:   decode_seg = 5'h0A;
      7'h7C:   decode_seg = 5'h0B;
      7'h39:   decode_seg = 5'h0C;
      7'h5E:   decode_seg = 5'h0D;
      7'h79:   decode_seg = 5'h0E;
      7'h71:   decode_seg = 5'h0F;
      default: decode_seg = 5'h10;
    endcase
  endfunction

  // Slot index of the low anode bit; only meaningful when exactly one is low.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) sel_idx = IW'(i);
    end
  end

  assign sel_valid = $onehot(~an_q);
  assign same      = (seg_q == seg_p) && (an_q == an_p);
  assign dec       = decode_seg(seg_q);
  assign seen_full = &seen;

  // Next stability count: zero on a bad select, restart on change, else saturate.
  always_comb begin
    if (!sel_valid)          cnt_next = '0;
    else if (!same)          cnt_next = CW'(1);
    else if (cnt == CNT_MAX) cnt_next = CNT_MAX;
    else                     cnt_next = cnt + CW'(1);
  end

  // One capture per stable episode: fires on the edge the count reaches the limit.
  assign capture = bus.En && armed && (cnt_next == CNT_MAX);

  // Input sampling, previous-sample history, stability counter and re-arm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      seg_p <= '0;
      an_q  <= '0;
      an_p  <= '0;
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      seg_q <= bus.seg;
      an_q  <= bus.an;
      seg_p <= seg_q;
      an_p  <= an_q;
      cnt   <= cnt_next;
      if (!bus.En || !same) armed <= 1'b1;
      else if (capture)     armed <= 1'b0;
    end
  end

  // Shadow capture, seen tracking and frame commit. A capture on the commit
  // edge lands in the freshly cleared seen mask, so it counts for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen       <= '0;
      shadow_val <= '0;
      shadow_err <= '0;
      digits_q   <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      if (!bus.En) begin
        seen <= '0;
      end else begin
        if (seen_full) begin
          digits_q <= shadow_val;
          err_q    <= shadow_err;
          fv_q     <= 1'b1;
        end
        seen <= (seen_full ? '0 : seen) | (capture ? ~an_q : '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (capture && (sel_idx == IW'(i))) begin
            shadow_val[4*i +: 4] <= dec[3:0];
            shadow_err[i]        <= dec[4];
          end
        end
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_err   = err_q;
  assign bus.frame_valid = fv_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scans, all
// checked every cycle against a run-length based reference model.
module tb_seg7_scan_decoder;
  localparam int ND = 4;
  localparam int S  = 4;
  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst_n;

  seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int             vectors = 0;
  int             errors  = 0;
  int             dut_frames = 0;
  logic [6:0]     m_prev_seg;
  logic [ND-1:0]  m_prev_an;
  int             m_run;
  bit             m_taken;
  bit             m_cap;
  int             m_slot;
  logic [4:0]     m_dec;
  logic [ND-1:0]  m_seen;
  logic [3:0]     m_sh_val [ND];
  logic [ND-1:0]  m_sh_err;
  logic [4*ND-1:0] exp_digits;
  logic [ND-1:0]  exp_err;
  logic           exp_fv;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int v = 0; v < 16; v++) begin
      if (PAT[v] == s) return {1'b0, 4'(v)};
    end
    return 5'h10;
  endfunction

  // The model keeps the length of the current run of identical samples; a run
  // at least S samples long on a single selected digit is captured once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev_seg = '0;
      m_prev_an  = '0;
      m_run      = 1;
      m_taken    = 1'b0;
      m_seen     = '0;
      for (int i = 0; i < ND; i++) m_sh_val[i] = '0;
      m_sh_err   = '0;
      exp_digits = '0;
      exp_err    = '0;
      exp_fv     = 1'b0;
    end else begin
      exp_fv = 1'b0;
      m_cap  = bus.En && ($countones(~m_prev_an) == 1) && (m_run >= S) && !m_taken;
      if (!bus.En) begin
        m_seen  = '0;
        m_taken = 1'b0;
      end else begin
        if (m_seen == {ND{1'b1}}) begin
          for (int i = 0; i < ND; i++) begin
            exp_digits[4*i +: 4] = m_sh_val[i];
            exp_err[i]           = m_sh_err[i];
          end
          exp_fv = 1'b1;
          m_seen = '0;
        end
        if (m_cap) begin
          m_slot = 0;
          for (int i = 0; i < ND; i++) if (!m_prev_an[i]) m_slot = i;
          m_dec            = ref_decode(m_prev_seg);
          m_sh_val[m_slot] = m_dec[3:0];
          m_sh_err[m_slot] = m_dec[4];
          m_seen[m_slot]   = 1'b1;
          m_taken          = 1'b1;
        end
      end
      if (bus.seg == m_prev_seg && bus.an == m_prev_an) begin
        m_run = m_run + 1;
      end else begin
        m_run   = 1;
        m_taken = 1'b0;
      end
      m_prev_seg = bus.seg;
      m_prev_an  = bus.an;
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge clk) begin
    vectors = vectors + 1;
    if ({bus.digits, bus.digit_err, bus.frame_valid} !== {exp_digits, exp_err, exp_fv}) begin
      errors = errors + 1;
      $display("FAIL cycle_compare t=%0t got digits=%h err=%b fv=%b want digits=%h err=%b fv=%b",
               $time, bus.digits, bus.digit_err, bus.frame_valid, exp_digits, exp_err, exp_fv);
    end
    if (bus.frame_valid === 1'b1) dut_frames = dut_frames + 1;
  end

  // ---------------- driver / check tasks ----------------
  function automatic logic [ND-1:0] an_of(input int d);
    logic [ND-1:0] m;
    m = '1;
    m[d] = 1'b0;
    return m;
  endfunction

  task automatic show(input logic [ND-1:0] an_v, input logic [6:0] seg_v, input int n);
    bus.an  = an_v;
    bus.seg = seg_v;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    show(an_of(0), s0, 8);
    show(an_of(1), s1, 8);
    show(an_of(2), s2, 8);
    show(an_of(3), s3, 8);
    show('1, 7'h00, 3);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  int f0;

  initial begin
    rst_n   = 1'b0;
    bus.En  = 1'b1;
    bus.an  = '1;
    bus.seg = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_digits", 32'(bus.digits), 32'h0);
    chk("reset_err", 32'(bus.digit_err), 32'h0);
    chk("reset_fv", 32'(bus.frame_valid), 32'h0);
    rst_n = 1'b1;
    show('1, 7'h00, 2);

    // nominal frame
    f0 = dut_frames;
    scan4(7'h39, 7'h3F, 7'h3F, 7'h3F);
    chk("nominal_digits", 32'(bus.digits), 32'h000C);
    chk("nominal_model", 32'(exp_digits), 32'h000C);
    chk("nominal_err", 32'(bus.digit_err), 32'h0);
    chk("nominal_frames", 32'(dut_frames - f0), 32'd1);

    // glitch rejection: a too-short 5B never lands, 4F does
    f0 = dut_frames;
    show(an_of(0), 7'h3F, 8);
    show(an_of(1), 7'h5B, S - 1);
    show(an_of(1), 7'h4F, 8);
    show(an_of(2), 7'h3F, 8);
    show(an_of(3), 7'h3F, 8);
    show('1, 7'h00, 3);
    chk("glitch_digits", 32'(bus.digits), 32'h0030);
    chk("glitch_model", 32'(exp_digits), 32'h0030);
    chk("glitch_frames", 32'(dut_frames - f0), 32'd1);

    // undecodable patterns
    f0 = dut_frames;
    scan4(7'h06, 7'h5B, 7'h00, 7'h7E);
    chk("invalid_digits", 32'(bus.digits), 32'h0021);
    chk("invalid_err", 32'(bus.digit_err), 32'hC);
    chk("invalid_model_err", 32'(exp_err), 32'hC);
    chk("invalid_frames", 32'(dut_frames - f0), 32'd1);

    // bad selects, then a clean scan
    f0 = dut_frames;
    show(4'b1111, 7'h06, 10);
    show(4'b0101, 7'h06, 10);
    chk("badsel_frames", 32'(dut_frames - f0), 32'd0);
    chk("badsel_hold", 32'(bus.digits), 32'h0021);
    scan4(7'h6D, 7'h7D, 7'h07, 7'h7F);
    chk("clean_digits", 32'(bus.digits), 32'h8765);
    chk("clean_err", 32'(bus.digit_err), 32'h0);
    chk("clean_frames", 32'(dut_frames - f0), 32'd1);

    // En gating
    f0 = dut_frames;
    show(an_of(0), 7'h7D, 8);
    show(an_of(1), 7'h06, 8);
    bus.En = 1'b0;
    show('1, 7'h00, 6);
    chk("en_hold_digits", 32'(bus.digits), 32'h8765);
    chk("en_hold_frames", 32'(dut_frames - f0), 32'd0);
    bus.En = 1'b1;
    scan4(7'h7D, 7'h06, 7'h77, 7'h71);
    chk("en_digits", 32'(bus.digits), 32'hFA16);
    chk("en_model", 32'(exp_digits), 32'hFA16);
    chk("en_frames", 32'(dut_frames - f0), 32'd1);

    // asynchronous reset in the middle of a scan
    show(an_of(0), 7'h3F, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(bus.digits), 32'h0);
    chk("async_rst_err", 32'(bus.digit_err), 32'h0);
    chk("async_rst_fv", 32'(bus.frame_valid), 32'h0);
    chk("async_rst_model", 32'(exp_digits), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = dut_frames;
    show(an_of(0), 7'h06, 8);
    show(an_of(1), 7'h5B, 8);
    show(an_of(2), 7'h4F, 8);
    show('1, 7'h00, 4);
    chk("post_rst_partial", 32'(dut_frames - f0), 32'd0);
    show(an_of(3), 7'h66, 8);
    show('1, 7'h00, 3);
    chk("post_rst_digits", 32'(bus.digits), 32'h4321);
    chk("post_rst_frames", 32'(dut_frames - f0), 32'd1);

    // randomized scans, checked cycle by cycle against the model
    for (int k = 0; k < 150; k++) begin
      logic [ND-1:0] a;
      logic [6:0]    s;
      if ($urandom_range(0, 9) == 0) a = ND'($urandom_range(0, (1 << ND) - 1));
      else if ($urandom_range(0, 4) == 0) a = an_of($urandom_range(0, ND - 1));
      else a = an_of(k % ND);
      if ($urandom_range(0, 7) == 0) s = 7'($urandom_range(0, 127));
      else s = PAT[$urandom_range(0, 15)];
      bus.En = ($urandom_range(0, 11) != 0);
      show(a, s, $urandom_range(1, 10));
    end
    bus.En = 1'b1;
    show('1, 7'h00, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the ALU-to-7-segment display path. It monitors a time-multiplexed 7-segment bus (segment lines plus per-digit anode selects) and recovers the 4-bit hex value shown on each digit. It reports a complete frame only after every digit has been observed stable. The block sits beside the display driver for self-check and loopback readback of the displayed ALU result.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits and anode lines (2..8).
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (2..255).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
En  input  1  capture enable; low clears frame progress and holds all outputs.
seg  input  7  segment lines {g,f,e,d,c,b,a}, active-high.
an  input  NUM_DIGITS  digit selects, active-low, one-hot-low when valid.
digits  output  4*NUM_DIGITS  decoded values; digit i occupies bits [4i+3:4i].
digit_err  output  NUM_DIGITS  bit i set when digit i showed an undecodable pattern in the last frame.
frame_valid  output  1  one-cycle pulse when digits/digit_err are updated.

Behaviour:
- Reset (async, rst_n=0): digits=0, digit_err=0, frame_valid=0, seen mask=0, stability counter=0, sample registers=0, armed=1.
- Input stage: seg and an registered every clk edge; all decisions use the registered copy.
- Stability counter:
  - Sample differs from previous sample: counter loads 1, armed=1.
  - Sample identical: counter increments, saturating at STABLE_CYCLES.
- Select qualification: an must have exactly one bit low. Zero or multiple low bits: counter held at 0, no capture.
- Capture: on the edge where counter reaches STABLE_CYCLES, armed=1 and En=1:
  - Slot i (index of the low an bit) written to a shadow register.
  - seen[i] set; armed cleared.
  - Exactly one capture per stable episode; re-showing the same digit after an changes re-captures and overwrites.
- Decode table (seg hex -> value): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
  - Any other pattern, including blank 00: shadow value=0, shadow err bit set, seen bit still set.
  - A valid decode clears that slot's shadow err bit.
- Frame completion:
  - When seen becomes all-ones, on the next edge digits<=shadow values, digit_err<=shadow errs, frame_valid=1 for exactly one cycle, seen cleared.
  - A capture on the same edge as frame commit counts toward the next frame.
- En=0: seen cleared, armed=1, no captures, frame_valid=0; digits/digit_err hold their values. The counter keeps tracking, so a pattern already stable when En rises needs no extra settle time.
- Latency: input constant from edge N captures at edge N+STABLE_CYCLES. frame_valid is asserted the edge after the final slot capture.
- Reset mid-frame: all progress lost. No frame_valid until every digit has been re-observed.

Test Plan:
- Reset: rst_n low mid-scan, asynchronously -> digits=0, digit_err=0, frame_valid=0 immediately, with no clock edge required.
- Nominal frame: 4 digits, each held 8 cycles; seg=39 on digit0, 3F on digits 1-3 -> single frame_valid pulse, digits=16'h000C, digit_err=0.
- Glitch rejection: digit1 shows 5B for only STABLE_CYCLES-1 cycles, then 4F held 8 cycles -> digit1 captured as 3; no capture of 2.
- Invalid pattern: digit2 shows 00 (blank) and digit3 shows 7E -> digit_err=4'b1100, digits[11:8]=0, digits[15:12]=0; frame_valid still pulses.
- Bad select: an=4'b1111, then an=4'b0101, each held 10 cycles -> no capture, seen unchanged. A following clean scan yields one frame.
- En gating: En dropped after 2 digits captured, then raised; full rescan with 7D,06,77,71 -> digits=16'hFA16, previous frame held until that pulse.
